// File: rtl/mem_readout_pkg.sv
// Shared constants and 9-bit modular helpers for the coefficient memory
// read and write controllers.
package mem_readout_pkg;

    localparam int SIZE    = 257;
    localparam int DEPTH   = 85;
    localparam int W       = 16;
    localparam int ADDR_W  = 7;
    localparam int SHIFT_W = 9;

    localparam logic [SHIFT_W-1:0] SHIFT_M0 = 9'd1;
    localparam logic [SHIFT_W-1:0] SHIFT_M1 = 9'd255;

    // (a + b) mod SIZE for operands already in 0..SIZE-1.
    function automatic logic [SHIFT_W-1:0] mod_add(input logic [SHIFT_W-1:0] a,
                                                   input logic [SHIFT_W-1:0] b);
        logic [SHIFT_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum >= 10'(SIZE)) begin
            sum = sum - 10'(SIZE);
        end
        return 9'(sum);
    endfunction

    // (a - b) mod SIZE for operands already in 0..SIZE-1.
    function automatic logic [SHIFT_W-1:0] mod_sub(input logic [SHIFT_W-1:0] a,
                                                   input logic [SHIFT_W-1:0] b);
        logic [SHIFT_W:0] diff;
        if (a >= b) begin
            diff = {1'b0, a} - {1'b0, b};
        end else begin
            diff = {1'b0, a} + 10'(SIZE) - {1'b0, b};
        end
        return 9'(diff);
    endfunction

endpackage

// File: rtl/mem_readout_row_rotator.sv
// Combinational SIZE-lane rotate: output lane i takes input lane
// (i + shift) mod SIZE. shift must be in 0..SIZE-1.
module mem_readout_row_rotator
    import mem_readout_pkg::*;
(
    input  logic [SIZE*W-1:0]  row_in,
    input  logic [SHIFT_W-1:0] shift,
    output logic [SIZE*W-1:0]  row_out
);

    logic [W-1:0] lane [SIZE];

    for (genvar j = 0; j < SIZE; j++) begin : g_unpack
        assign lane[j] = row_in[j*W +: W];
    end

    for (genvar i = 0; i < SIZE; i++) begin : g_lane
        assign row_out[i*W +: W] = lane[mod_add(9'(i), shift)];
    end

endmodule

// File: rtl/mem_readout.sv
// Reads the DEPTH rows of a pass back in order, undoes the per-row rotation
// and streams each row as one beat through a 2-entry output FIFO.
//
//   state    | meaning
//   ---------+--------------------------------------------------------
//   ST_IDLE  | waiting for start
//   ST_READ  | issuing row reads 0..DEPTH-1, throttled by FIFO room
//   ST_DRAIN | all reads issued, waiting for the last beat to be taken
module mem_readout
    import mem_readout_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               soft_reset,
    input  logic               start,
    input  logic               mode,
    output logic               rd_en,
    output logic [ADDR_W-1:0]  rd_addr,
    input  logic [SIZE*W-1:0]  rd_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SIZE*W-1:0]  out_data,
    output logic               out_last,
    output logic               busy,
    output logic               done
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]         state;
    logic               mode_q;
    logic [ADDR_W-1:0]  addr;
    logic [SHIFT_W-1:0] shift;
    logic [SHIFT_W-1:0] shift_next;
    logic               last_row;

    // Read request pipeline: data for a read issued last cycle is on rd_data now.
    logic               inflight;
    logic [SHIFT_W-1:0] inflight_shift;
    logic               inflight_last;

    logic [SIZE*W-1:0]  fifo_data [2];
    logic [1:0]         fifo_last;
    logic               wr_ptr;
    logic               rd_ptr;
    logic [1:0]         count;
    logic               push;
    logic               pop;
    logic [SIZE*W-1:0]  rot_data;

    mem_readout_row_rotator u_row_rotator (
        .row_in  (rd_data),
        .shift   (inflight_shift),
        .row_out (rot_data)
    );

    assign push       = inflight;
    assign out_valid  = (count != 2'd0);
    assign pop        = out_valid && out_ready;
    assign out_data   = out_valid ? fifo_data[rd_ptr] : '0;
    assign out_last   = out_valid && fifo_last[rd_ptr];
    assign busy       = (state != ST_IDLE);
    assign rd_addr    = addr;
    assign last_row   = (addr == 7'(DEPTH - 1));
    assign shift_next = mode_q ? mod_add(shift, SHIFT_M1) : mod_sub(shift, SHIFT_M0);

    // Buffered rows plus the one in flight never exceed the two FIFO slots;
    // a pop this cycle frees a slot for the read issued now.
    assign rd_en = (state == ST_READ) && !soft_reset &&
                   ((({1'b0, count} + {2'b00, inflight}) < 3'd2) || pop);

    // Control: FSM, address/shift sequencing, read pipeline and FIFO bookkeeping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= ST_IDLE;
            mode_q         <= 1'b0;
            addr           <= '0;
            shift          <= '0;
            inflight       <= 1'b0;
            inflight_shift <= '0;
            inflight_last  <= 1'b0;
            fifo_last      <= '0;
            wr_ptr         <= 1'b0;
            rd_ptr         <= 1'b0;
            count          <= '0;
            done           <= 1'b0;
        end else if (soft_reset) begin
            state          <= ST_IDLE;
            mode_q         <= 1'b0;
            addr           <= '0;
            shift          <= '0;
            inflight       <= 1'b0;
            inflight_shift <= '0;
            inflight_last  <= 1'b0;
            fifo_last      <= '0;
            wr_ptr         <= 1'b0;
            rd_ptr         <= 1'b0;
            count          <= '0;
            done           <= 1'b0;
        end else begin
            done     <= 1'b0;
            inflight <= rd_en;
            if (rd_en) begin
                inflight_shift <= shift;
                inflight_last  <= last_row;
            end

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state  <= ST_READ;
                        mode_q <= mode;
                        addr   <= '0;
                        shift  <= '0;
                    end
                end
                ST_READ: begin
                    if (rd_en) begin
                        if (last_row) begin
                            state <= ST_DRAIN;
                            addr  <= '0;
                            shift <= '0;
                        end else begin
                            addr  <= addr + 7'd1;
                            shift <= shift_next;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (pop && fifo_last[rd_ptr]) begin
                        state <= ST_IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            if (push) begin
                fifo_last[wr_ptr] <= inflight_last;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    // Row storage: entries are only visible while count covers them, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= rot_data;
        end
    end

endmodule

// File: tb/tb_mem_readout.sv
module tb_mem_readout;
    import mem_readout_pkg::*;

    logic               clk = 1'b0;
    logic               reset;
    logic               soft_reset;
    logic               start;
    logic               mode;
    logic               rd_en;
    logic [ADDR_W-1:0]  rd_addr;
    logic [SIZE*W-1:0]  rd_data;
    logic               out_valid;
    logic               out_ready;
    logic [SIZE*W-1:0]  out_data;
    logic               out_last;
    logic               busy;
    logic               done;

    int asserts = 0;
    int fails   = 0;
    int cyc     = 0;
    int data_ofs;
    bit clr_req;

    // monitor state (written only by the monitor)
    logic [SIZE*W-1:0] q_data [$];
    bit                q_last [$];
    int                q_cyc  [$];
    int issued, accepted, max_out, stall_err, done_cnt, done_cyc, first_issue, valid_cnt;
    bit                held;
    logic [SIZE*W-1:0] held_data;
    logic              held_last;

    mem_readout dut (
        .clk        (clk),
        .reset      (reset),
        .soft_reset (soft_reset),
        .start      (start),
        .mode       (mode),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    function automatic logic [W-1:0] lane_val(int r, int j);
        int t;
        t = r * 1000 + j + data_ofs;
        return t[W-1:0];
    endfunction

    function automatic logic [SIZE*W-1:0] mem_row(int r);
        logic [SIZE*W-1:0] v;
        for (int j = 0; j < SIZE; j++) v[j*W +: W] = lane_val(r, j);
        return v;
    endfunction

    // Row k was rotated by -k (mode 0) or -2k (mode 1) modulo SIZE.
    function automatic logic [SIZE*W-1:0] exp_row(int k, bit m);
        logic [SIZE*W-1:0] v;
        int s;
        s = m ? (k * 255) % SIZE : (SIZE - (k % SIZE)) % SIZE;
        for (int i = 0; i < SIZE; i++) v[i*W +: W] = lane_val(k, (i + s) % SIZE);
        return v;
    endfunction

    // bank array: registered read, data valid one cycle after rd_en
    always @(posedge clk) begin
        if (rd_en === 1'b1) rd_data <= mem_row(int'(rd_addr));
    end

    // observer sampling on the falling edge
    always @(negedge clk) begin
        if (clr_req) begin
            q_data.delete(); q_last.delete(); q_cyc.delete();
            issued = 0; accepted = 0; max_out = 0; stall_err = 0;
            done_cnt = 0; done_cyc = -1; first_issue = -1; valid_cnt = 0; held = 0;
        end else begin
            if (rd_en === 1'b1) begin
                if (first_issue < 0) first_issue = cyc;
                issued++;
            end
            if (out_valid === 1'b1) valid_cnt++;
            if (held && (out_valid !== 1'b1 || out_data !== held_data || out_last !== held_last))
                stall_err++;
            held      = (out_valid === 1'b1) && (out_ready === 1'b0);
            held_data = out_data;
            held_last = out_last;
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                q_data.push_back(out_data);
                q_last.push_back(out_last);
                q_cyc.push_back(cyc);
                accepted++;
            end
            if (issued - accepted > max_out) max_out = issued - accepted;
            if (done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
    endtask

    task automatic run_pass(input bit m, input int pct, input int mid_start,
                            output bit timed_out, output int t_start, output bit early);
        clear_mon();
        out_ready = ($urandom_range(0, 99) < pct);
        start     = 1'b1;
        mode      = m;
        t_start   = cyc;
        #2;
        early = busy | done;
        tick();
        start = 1'b0;
        mode  = 1'($urandom_range(0, 1));
        timed_out = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            out_ready = (pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < pct);
            if (c == mid_start) begin
                start = 1'b1;
                mode  = ~m;
            end else begin
                start = 1'b0;
            end
            if (done_cnt != 0) begin
                timed_out = 1'b0;
                break;
            end
            tick();
        end
        start     = 1'b0;
        out_ready = 1'b1;
        repeat (4) tick();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0;
        repeat (2) tick();
        asserts++; if (rd_en !== 1'b0)     begin fails++; $display("FAIL reset_rd_en: got %b want 0", rd_en); end
        asserts++; if (rd_addr !== 7'd0)   begin fails++; $display("FAIL reset_rd_addr: got %0d want 0", rd_addr); end
        asserts++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        asserts++; if (out_data !== '0)    begin fails++; $display("FAIL reset_out_data: lane0 got %0h want 0", out_data[W-1:0]); end
        asserts++; if (out_last !== 1'b0)  begin fails++; $display("FAIL reset_out_last: got %b want 0", out_last); end
        asserts++; if (busy !== 1'b0)      begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
        asserts++; if (done !== 1'b0)      begin fails++; $display("FAIL reset_done: got %b want 0", done); end
        reset = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_mode0();
        bit to, early; int ts, nlast, lastpos;
        logic [SIZE*W-1:0] got, exp;
        data_ofs = 0;
        run_pass(1'b0, 100, -1, to, ts, early);
        asserts++; if (to) begin fails++; $display("FAIL m0_timeout: done not seen within budget"); end
        asserts++; if (early !== 1'b0) begin fails++; $display("FAIL m0_comb_busy: busy|done got %b want 0 before edge", early); end
        asserts++; if (first_issue != ts + 1) begin fails++; $display("FAIL m0_first_read: cycle got %0d want %0d", first_issue, ts + 1); end
        asserts++; if (q_data.size() != DEPTH) begin fails++; $display("FAIL m0_beats: got %0d want %0d", q_data.size(), DEPTH); end
        if (q_data.size() == DEPTH) begin
            got = q_data[0];
            asserts++; if (got[0 +: W] !== 16'd0) begin fails++; $display("FAIL m0_b0l0: got %0d want 0", got[0 +: W]); end
            got = q_data[1];
            asserts++; if (got[0 +: W] !== 16'd1256) begin fails++; $display("FAIL m0_b1l0: got %0d want 1256", got[0 +: W]); end
            asserts++; if (got[W +: W] !== 16'd1000) begin fails++; $display("FAIL m0_b1l1: got %0d want 1000", got[W +: W]); end
            asserts++; if (q_cyc[0] != ts + 3) begin fails++; $display("FAIL m0_latency: first beat cycle got %0d want %0d", q_cyc[0], ts + 3); end
            asserts++; if (q_cyc[DEPTH-1] - q_cyc[0] != DEPTH - 1) begin fails++; $display("FAIL m0_bubbles: span got %0d want %0d", q_cyc[DEPTH-1] - q_cyc[0], DEPTH - 1); end
            asserts++; if (done_cyc != q_cyc[DEPTH-1] + 1) begin fails++; $display("FAIL m0_done_time: got %0d want %0d", done_cyc, q_cyc[DEPTH-1] + 1); end
        end
        for (int k = 0; k < q_data.size(); k++) begin
            got = q_data[k]; exp = exp_row(k, 1'b0);
            asserts++; if (got !== exp) begin fails++; $display("FAIL m0_row%0d: lane0 got %0d want %0d", k, got[0 +: W], exp[0 +: W]); end
        end
        nlast = 0; lastpos = -1;
        for (int k = 0; k < q_last.size(); k++) if (q_last[k]) begin nlast++; lastpos = k; end
        asserts++; if (nlast != 1 || lastpos != DEPTH - 1) begin fails++; $display("FAIL m0_last: count %0d at %0d want 1 at %0d", nlast, lastpos, DEPTH - 1); end
        asserts++; if (done_cnt != 1) begin fails++; $display("FAIL m0_done_count: got %0d want 1", done_cnt); end
        asserts++; if (busy !== 1'b0) begin fails++; $display("FAIL m0_busy_end: got %b want 0", busy); end
    endtask

    task automatic test_mode1();
        bit to, early; int ts;
        logic [SIZE*W-1:0] got, exp;
        data_ofs = 0;
        run_pass(1'b1, 100, -1, to, ts, early);
        asserts++; if (to) begin fails++; $display("FAIL m1_timeout: done not seen within budget"); end
        asserts++; if (q_data.size() != DEPTH) begin fails++; $display("FAIL m1_beats: got %0d want %0d", q_data.size(), DEPTH); end
        if (q_data.size() == DEPTH) begin
            got = q_data[1];
            asserts++; if (got[0 +: W] !== 16'd1255) begin fails++; $display("FAIL m1_b1l0: got %0d want 1255", got[0 +: W]); end
            asserts++; if (got[2*W +: W] !== 16'd1000) begin fails++; $display("FAIL m1_b1l2: got %0d want 1000", got[2*W +: W]); end
            got = q_data[2];
            asserts++; if (got[0 +: W] !== 16'd2253) begin fails++; $display("FAIL m1_b2l0: got %0d want 2253", got[0 +: W]); end
        end
        for (int k = 0; k < q_data.size(); k++) begin
            got = q_data[k]; exp = exp_row(k, 1'b1);
            asserts++; if (got !== exp) begin fails++; $display("FAIL m1_row%0d: lane0 got %0d want %0d", k, got[0 +: W], exp[0 +: W]); end
        end
        asserts++; if (done_cnt != 1) begin fails++; $display("FAIL m1_done_count: got %0d want 1", done_cnt); end
    endtask

    task automatic test_random_ready();
        bit to, early, m; int ts, nlast, lastpos;
        logic [SIZE*W-1:0] got, exp;
        for (int it = 0; it < 3; it++) begin
            data_ofs = $urandom_range(0, 60000);
            m = 1'($urandom_range(0, 1));
            run_pass(m, 30, -1, to, ts, early);
            asserts++; if (to) begin fails++; $display("FAIL rr%0d_timeout: done not seen within budget", it); end
            asserts++; if (q_data.size() != DEPTH) begin fails++; $display("FAIL rr%0d_beats: got %0d want %0d", it, q_data.size(), DEPTH); end
            for (int k = 0; k < q_data.size(); k++) begin
                got = q_data[k]; exp = exp_row(k, m);
                asserts++; if (got !== exp) begin fails++; $display("FAIL rr%0d_row%0d: lane0 got %0d want %0d", it, k, got[0 +: W], exp[0 +: W]); end
            end
            nlast = 0; lastpos = -1;
            for (int k = 0; k < q_last.size(); k++) if (q_last[k]) begin nlast++; lastpos = k; end
            asserts++; if (nlast != 1 || lastpos != DEPTH - 1) begin fails++; $display("FAIL rr%0d_last: count %0d at %0d want 1 at %0d", it, nlast, lastpos, DEPTH - 1); end
            asserts++; if (stall_err != 0) begin fails++; $display("FAIL rr%0d_stable: %0d changes while stalled, want 0", it, stall_err); end
            asserts++; if (max_out > 2) begin fails++; $display("FAIL rr%0d_outstanding: max %0d want <= 2", it, max_out); end
            asserts++; if (done_cnt != 1) begin fails++; $display("FAIL rr%0d_done_count: got %0d want 1", it, done_cnt); end
        end
    endtask

    task automatic test_start_ignored();
        bit to, early; int ts;
        logic [SIZE*W-1:0] got, exp;
        data_ofs = $urandom_range(0, 60000);
        run_pass(1'b0, 60, 20, to, ts, early);
        asserts++; if (to) begin fails++; $display("FAIL si_timeout: done not seen within budget"); end
        asserts++; if (q_data.size() != DEPTH) begin fails++; $display("FAIL si_beats: got %0d want %0d", q_data.size(), DEPTH); end
        for (int k = 0; k < q_data.size(); k++) begin
            got = q_data[k]; exp = exp_row(k, 1'b0);
            asserts++; if (got !== exp) begin fails++; $display("FAIL si_row%0d: lane0 got %0d want %0d", k, got[0 +: W], exp[0 +: W]); end
        end
        asserts++; if (done_cnt != 1) begin fails++; $display("FAIL si_done_count: got %0d want 1", done_cnt); end
        asserts++; if (busy !== 1'b0) begin fails++; $display("FAIL si_busy_end: got %b want 0", busy); end
    endtask

    task automatic test_reset_mid();
        bit to, early, reached; int ts;
        logic [SIZE*W-1:0] got, exp;
        data_ofs = $urandom_range(0, 60000);
        clear_mon();
        out_ready = 1'b1; start = 1'b1; mode = 1'b0;
        tick();
        start = 1'b0;
        reached = 1'b0;
        for (int c = 0; c < 500; c++) begin
            if (accepted >= 40) begin reached = 1'b1; break; end
            tick();
        end
        asserts++; if (!reached) begin fails++; $display("FAIL rm_reach40: accepted %0d want 40", accepted); end
        reset = 1'b0;
        #1;
        asserts++; if (rd_en !== 1'b0)     begin fails++; $display("FAIL rm_rd_en: got %b want 0", rd_en); end
        asserts++; if (rd_addr !== 7'd0)   begin fails++; $display("FAIL rm_rd_addr: got %0d want 0", rd_addr); end
        asserts++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rm_out_valid: got %b want 0", out_valid); end
        asserts++; if (out_data !== '0)    begin fails++; $display("FAIL rm_out_data: lane0 got %0h want 0", out_data[W-1:0]); end
        asserts++; if (out_last !== 1'b0)  begin fails++; $display("FAIL rm_out_last: got %b want 0", out_last); end
        asserts++; if (busy !== 1'b0)      begin fails++; $display("FAIL rm_busy: got %b want 0", busy); end
        asserts++; if (done !== 1'b0)      begin fails++; $display("FAIL rm_done: got %b want 0", done); end
        tick();
        reset = 1'b1;
        tick();
        run_pass(1'b0, 100, -1, to, ts, early);
        asserts++; if (to) begin fails++; $display("FAIL rm_restart_timeout: done not seen within budget"); end
        asserts++; if (q_data.size() != DEPTH) begin fails++; $display("FAIL rm_beats: got %0d want %0d", q_data.size(), DEPTH); end
        for (int k = 0; k < q_data.size(); k++) begin
            got = q_data[k]; exp = exp_row(k, 1'b0);
            asserts++; if (got !== exp) begin fails++; $display("FAIL rm_row%0d: lane0 got %0d want %0d", k, got[0 +: W], exp[0 +: W]); end
        end
    endtask

    task automatic test_soft_reset();
        data_ofs = 0;
        clear_mon();
        out_ready = 1'b1; start = 1'b1; mode = 1'b1;
        tick();
        start = 1'b0;
        tick();
        soft_reset = 1'b1;
        tick();
        soft_reset = 1'b0;
        repeat (20) tick();
        asserts++; if (issued != 1)    begin fails++; $display("FAIL sr_issued: got %0d want 1", issued); end
        asserts++; if (valid_cnt != 0) begin fails++; $display("FAIL sr_valid: out_valid cycles got %0d want 0", valid_cnt); end
        asserts++; if (done_cnt != 0)  begin fails++; $display("FAIL sr_done: pulses got %0d want 0", done_cnt); end
        asserts++; if (busy !== 1'b0)  begin fails++; $display("FAIL sr_busy: got %b want 0", busy); end
    endtask

    task automatic test_back_to_back();
        bit to, early; int ts;
        logic [SIZE*W-1:0] got, exp;
        for (int p = 0; p < 2; p++) begin
            data_ofs = $urandom_range(0, 60000);
            run_pass(1'(p), 70, -1, to, ts, early);
            asserts++; if (to) begin fails++; $display("FAIL bb%0d_timeout: done not seen within budget", p); end
            asserts++; if (q_data.size() != DEPTH) begin fails++; $display("FAIL bb%0d_beats: got %0d want %0d", p, q_data.size(), DEPTH); end
            for (int k = 0; k < q_data.size(); k++) begin
                got = q_data[k]; exp = exp_row(k, 1'(p));
                asserts++; if (got !== exp) begin fails++; $display("FAIL bb%0d_row%0d: lane0 got %0d want %0d", p, k, got[0 +: W], exp[0 +: W]); end
            end
            asserts++; if (max_out > 2) begin fails++; $display("FAIL bb%0d_outstanding: max %0d want <= 2", p, max_out); end
        end
    endtask

    initial begin
        reset = 1'b0; soft_reset = 1'b0; start = 1'b0; mode = 1'b0;
        out_ready = 1'b0; clr_req = 1'b0; data_ofs = 0;
        test_reset();
        test_mode0();
        test_mode1();
        test_random_ready();
        test_start_ignored();
        test_reset_mid();
        test_soft_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
